instr_fetch_unit: RTL

Instruction fetch stage for the tiny RISC-V core: it sits upstream of the decode/execute stage and drives the synchronous instruction memory. Each returned word is tagged with its PC and held in a small prefetch queue, and instructions are delivered downstream over a valid/ready handshake. A redirect input (branch/jump from execute) flushes the queue, discards the in-flight read, and restarts fetch at a new PC.

---
 rtl/instr_fetch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues reads to a synchronous instruction memory,
// tags returned words with their PC in a prefetch queue, and supports redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IMEM_AW  = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pend_valid;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Occupancy counts the in-flight read so a returning word always has a slot.
  always_comb begin
    occupancy = count + CW'(pend_valid);
    issue     = RST_N && !redirect_valid && (occupancy < CW'(DEPTH));
    push      = pend_valid && !redirect_valid;
    pop       = out_valid && out_ready;
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign out_valid = (count != '0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc   <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      pend_valid <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      pend_valid <= issue;
      if (issue) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr]    <= pend_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule
